// File: rtl/bsg_downstream_pkg.sv
// Shared constants and read-FSM state encoding for the downstream channel.
package bsg_downstream_pkg;

  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned PTR_W       = ADDR_W + 1;
  localparam int unsigned TOKEN_BATCH = 4;

  typedef enum logic [2:0] {
    FETCH_LO = 3'd0,
    CAP_LO   = 3'd1,
    FETCH_HI = 3'd2,
    CAP_HI   = 3'd3,
    PRESENT  = 3'd4
  } rd_state_e;

endpackage

// File: rtl/bsg_token_batcher.sv
// Counts read pulses and emits one registered credit pulse per TOKEN_BATCH reads.
module bsg_token_batcher #(
  parameter int unsigned TOKEN_BATCH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic read_pulse,
  output logic token_out
);

  localparam int unsigned CNT_W = $clog2(TOKEN_BATCH);

  generate
    if (CNT_W == 0) begin : g_every
      // Batch of one: every read is a credit.
      always_ff @(posedge clk) begin
        if (rst) token_out <= 1'b0;
        else     token_out <= read_pulse;
      end
    end else begin : g_count
      logic [CNT_W-1:0] cnt;

      // Pulse on the cycle after the read that wraps the counter to zero.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt       <= '0;
          token_out <= 1'b0;
        end else begin
          token_out <= read_pulse && (cnt == {CNT_W{1'b1}});
          if (read_pulse) cnt <= cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/bsg_downstream_read_ctrl.sv
// Drains the receive buffer in order, pairs entries into 32-bit core words,
// and returns batched credits to the sender.
module bsg_downstream_read_ctrl #(
  parameter int unsigned ADDR_W      = bsg_downstream_pkg::ADDR_W,
  parameter int unsigned TOKEN_BATCH = bsg_downstream_pkg::TOKEN_BATCH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr,
  output logic [ADDR_W:0]   rptr,
  output logic [ADDR_W-1:0] buffer_raddr,
  output logic              buffer_ren,
  input  logic [15:0]       buffer_rdata,
  output logic [31:0]       core_data_out,
  output logic              core_valid_out,
  input  logic              core_ready,
  output logic              io_token_out,
  output logic              overrun
);

  import bsg_downstream_pkg::*;

  localparam int unsigned PTR_BITS = ADDR_W + 1;
  localparam int unsigned DEPTH    = 1 << ADDR_W;

  rd_state_e         state, state_d;
  logic [ADDR_W:0]   rptr_d;
  logic [ADDR_W:0]   count;
  logic [15:0]       lo, lo_d;
  logic [31:0]       data_d;
  logic              valid_d;
  logic              empty;

  assign empty = (wptr == rptr);
  assign count = wptr - rptr;

  // State register and registered datapath/outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH_LO;
      rptr           <= '0;
      lo             <= '0;
      core_data_out  <= '0;
      core_valid_out <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state          <= state_d;
      rptr           <= rptr_d;
      lo             <= lo_d;
      core_data_out  <= data_d;
      core_valid_out <= valid_d;
      overrun        <= overrun | (count > PTR_BITS'(DEPTH));
    end
  end

  // Next-state, read issue and word assembly.
  always_comb begin
    state_d      = state;
    rptr_d       = rptr;
    lo_d         = lo;
    data_d       = core_data_out;
    valid_d      = core_valid_out;
    buffer_ren   = 1'b0;
    buffer_raddr = rptr[ADDR_W-1:0];
    case (state)
      FETCH_LO: begin
        if (!empty) begin
          buffer_ren = 1'b1;
          rptr_d     = rptr + PTR_BITS'(1);
          state_d    = CAP_LO;
        end
      end
      CAP_LO: begin
        lo_d    = buffer_rdata;
        state_d = FETCH_HI;
      end
      FETCH_HI: begin
        if (!empty) begin
          buffer_ren = 1'b1;
          rptr_d     = rptr + PTR_BITS'(1);
          state_d    = CAP_HI;
        end
      end
      CAP_HI: begin
        data_d  = {buffer_rdata, lo};
        valid_d = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (core_ready) begin
          valid_d = 1'b0;
          state_d = FETCH_LO;
        end
      end
      default: state_d = FETCH_LO;
    endcase
  end

  // Credits are counted per issued read.
  bsg_token_batcher #(
    .TOKEN_BATCH(TOKEN_BATCH)
  ) u_token_batcher (
    .clk       (clk),
    .rst       (rst),
    .read_pulse(buffer_ren),
    .token_out (io_token_out)
  );

endmodule

// File: tb/tb_bsg_downstream_read_ctrl.sv
// Directed bench for the downstream read controller with a behavioural buffer.
module tb_bsg_downstream_read_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  wptr;
  logic [6:0]  rptr;
  logic [5:0]  buffer_raddr;
  logic        buffer_ren;
  logic [15:0] buffer_rdata;
  logic [31:0] core_data_out;
  logic        core_valid_out;
  logic        core_ready;
  logic        io_token_out;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [64];

  typedef struct {
    logic [6:0]  wptr;
    logic        ready;
    logic        exp_ren;
    logic [5:0]  exp_raddr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [6:0]  exp_rptr;
  } vec_t;

  vec_t vt [32];
  int   nv = 0;

  always #5 clk = ~clk;

  // Buffer read data arrives one cycle after the enable.
  always @(posedge clk) if (buffer_ren) buffer_rdata <= mem[buffer_raddr];

  bsg_downstream_read_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .wptr          (wptr),
    .rptr          (rptr),
    .buffer_raddr  (buffer_raddr),
    .buffer_ren    (buffer_ren),
    .buffer_rdata  (buffer_rdata),
    .core_data_out (core_data_out),
    .core_valid_out(core_valid_out),
    .core_ready    (core_ready),
    .io_token_out  (io_token_out),
    .overrun       (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wptr = '0; core_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic add(input logic [6:0] w, input logic r, input logic ren, input logic [5:0] ra,
                     input logic v, input logic [31:0] d, input logic [6:0] rp);
    vt[nv] = '{w, r, ren, ra, v, d, rp};
    nv++;
  endtask

  function automatic logic [15:0] val(input int k);
    return 16'(k * 257 + 32'h1234);
  endfunction

  initial begin
    int p, words, reads, pulses;
    logic pend_tok, saw_wrap;
    logic [6:0] prev_rptr;

    buffer_rdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 16'h3412; mem[1] = 16'h7856; mem[2] = 16'hBC9A; mem[3] = 16'hF0DE;

    // Basic fetch of two entries, then backpressure, then the next word.
    add(7'd0, 0, 0, 6'd0, 0, 32'h0, 7'd0);
    add(7'd2, 0, 1, 6'd0, 0, 32'h0, 7'd0);
    add(7'd2, 0, 0, 6'd0, 0, 32'h0, 7'd1);
    add(7'd2, 0, 1, 6'd1, 0, 32'h0, 7'd1);
    add(7'd2, 0, 0, 6'd0, 0, 32'h0, 7'd2);
    for (int i = 0; i < 10; i++) add(7'd6, 0, 0, 6'd0, 1, 32'h78563412, 7'd2);
    add(7'd6, 1, 0, 6'd0, 1, 32'h78563412, 7'd2);
    add(7'd6, 0, 1, 6'd2, 0, 32'h0, 7'd2);
    add(7'd6, 0, 0, 6'd0, 0, 32'h0, 7'd3);
    add(7'd6, 0, 1, 6'd3, 0, 32'h0, 7'd3);
    add(7'd6, 0, 0, 6'd0, 0, 32'h0, 7'd4);
    add(7'd6, 0, 0, 6'd0, 1, 32'hF0DEBC9A, 7'd4);

    do_reset();
    chk("reset_valid", 32'(core_valid_out), 32'd0);
    chk("reset_rptr", 32'(rptr), 32'd0);
    for (int i = 0; i < nv; i++) begin
      wptr = vt[i].wptr; core_ready = vt[i].ready;
      #1;
      chk($sformatf("vec%0d_ren", i), 32'(buffer_ren), 32'(vt[i].exp_ren));
      if (vt[i].exp_ren) chk($sformatf("vec%0d_raddr", i), 32'(buffer_raddr), 32'(vt[i].exp_raddr));
      chk($sformatf("vec%0d_valid", i), 32'(core_valid_out), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) chk($sformatf("vec%0d_data", i), core_data_out, vt[i].exp_data);
      chk($sformatf("vec%0d_rptr", i), 32'(rptr), 32'(vt[i].exp_rptr));
      step();
    end

    // Reset while presenting, with ready high in the same cycle.
    chk("pre_rst_valid", 32'(core_valid_out), 32'd1);
    rst = 1'b1; core_ready = 1'b1; wptr = '0;
    step();
    chk("rst_valid", 32'(core_valid_out), 32'd0);
    chk("rst_data", core_data_out, 32'd0);
    chk("rst_rptr", 32'(rptr), 32'd0);
    chk("rst_token", 32'(io_token_out), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_ren", 32'(buffer_ren), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(core_valid_out), 32'd0);
    wptr = 7'd2; #1;
    chk("post_rst_fetch_lo_ren", 32'(buffer_ren), 32'd1);
    chk("post_rst_fetch_lo_raddr", 32'(buffer_raddr), 32'd0);

    // Partial word: park in FETCH_HI, then complete.
    do_reset();
    wptr = 7'd1;
    step(); step(); step();
    chk("part_rptr", 32'(rptr), 32'd1);
    chk("part_valid", 32'(core_valid_out), 32'd0);
    chk("part_ren", 32'(buffer_ren), 32'd0);
    wptr = 7'd2; #1;
    chk("part_ren_hi", 32'(buffer_ren), 32'd1);
    chk("part_raddr_hi", 32'(buffer_raddr), 32'd1);
    step();
    chk("part_valid_u1", 32'(core_valid_out), 32'd0);
    step();
    chk("part_valid_u2", 32'(core_valid_out), 32'd1);
    chk("part_data", core_data_out, 32'h78563412);

    // Overrun boundary and stickiness.
    do_reset();
    wptr = 7'd64;
    step();
    chk("ovr_at_depth", 32'(overrun), 32'd0);
    do_reset();
    wptr = 7'd65;
    step();
    chk("ovr_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    do_reset();
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Streaming across pointer wrap with credit tracking.
    do_reset();
    core_ready = 1'b1;
    p = 0; words = 0; reads = 0; pulses = 0;
    pend_tok = 1'b0; saw_wrap = 1'b0; prev_rptr = rptr;
    for (int cyc = 0; cyc < 3000 && words < 65; cyc++) begin
      if (core_valid_out && core_ready) begin
        chk($sformatf("stream_word%0d", words), core_data_out,
            {val(2 * words + 1), val(2 * words)});
        words++;
      end
      chk("stream_token", 32'(io_token_out), 32'(pend_tok));
      if (io_token_out) pulses++;
      if (prev_rptr == 7'd127 && rptr == 7'd0) saw_wrap = 1'b1;
      prev_rptr = rptr;
      if (p < 130 && 7'(wptr - rptr) < 7'd16) begin
        mem[p % 64] = val(p);
        p++;
        wptr = 7'(p);
      end
      #1;
      pend_tok = 1'b0;
      if (buffer_ren) begin
        reads++;
        pend_tok = (reads % 4 == 0);
      end
      step();
    end
    chk("stream_words", 32'(words), 32'd65);
    chk("stream_reads", 32'(reads), 32'd130);
    chk("stream_pulses", 32'(pulses), 32'd32);
    chk("stream_wrap", 32'(saw_wrap), 32'd1);
    chk("stream_rptr_end", 32'(rptr), 32'd2);
    chk("stream_overrun", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_downstream_read_ctrl.md
# bsg_downstream_read_ctrl

Read-side controller for the downstream channel's 64-entry, 16-bit receive buffer. It tracks the write pointer published by the byte-pairing input stage and reads entries out in order. It assembles two consecutive entries into one 32-bit core word and presents that word on a valid/ready handshake. It also returns flow-control credits to the off-chip sender as batched token pulses.

## Interface
Parameters:
- ADDR_W, 6: buffer address width; depth = 2^ADDR_W entries; pointers are ADDR_W+1 bits (MSB = wrap bit).
- TOKEN_BATCH, 4: entries freed per io_token_out pulse; must be a power of two, ≥1.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- wptr  in  ADDR_W+1  write pointer from the input stage; entry count = (wptr − rptr) mod 2^(ADDR_W+1).
- rptr  out  ADDR_W+1  read pointer, returned to the input stage for its full computation.
- buffer_raddr  out  ADDR_W  read address; equals rptr[ADDR_W-1:0] when buffer_ren=1.
- buffer_ren  out  1  read enable.
- buffer_rdata  in  16  read data; valid exactly one cycle after buffer_ren.
- core_data_out  out  32  assembled word {second entry, first entry}.
- core_valid_out  out  1  word valid.
- core_ready  in  1  core accepts the word when valid and ready are both 1.
- io_token_out  out  1  one-cycle credit pulse per TOKEN_BATCH freed entries.
- overrun  out  1  sticky protocol-error flag.

## Operation
- empty = (wptr == rptr), all ADDR_W+1 bits compared.
- FSM states, with reset state FETCH_LO:
  - FETCH_LO: if !empty, assert buffer_ren, set rptr <= rptr+1, go to CAP_LO. Otherwise stay.
  - CAP_LO: capture buffer_rdata into the low-half register, go to FETCH_HI.
  - FETCH_HI: if !empty, assert buffer_ren, set rptr <= rptr+1, go to CAP_HI. Otherwise stay; the low half is held.
  - CAP_HI: set core_data_out <= {buffer_rdata, lo}, core_valid_out <= 1, go to PRESENT.
  - PRESENT: hold core_data_out and core_valid_out until core_ready=1. On handshake, core_valid_out <= 0 and go to FETCH_LO.
- No buffer read is issued outside FETCH_LO and FETCH_HI. Backpressure therefore stalls buffer drain, which stalls credits.
- core_ready is ignored while core_valid_out=0.
- An entry counts as freed when its read is issued, i.e. when rptr advances.
- Token counter: width log2(TOKEN_BATCH), incremented on each read. The read that wraps the counter to 0 causes io_token_out=1 on the following cycle, for exactly one cycle. With TOKEN_BATCH=1, every read produces a pulse.
- rptr wraps naturally from 2^(ADDR_W+1)−1 to 0. buffer_raddr wraps from 2^ADDR_W−1 to 0.
- overrun is set when the entry count exceeds 2^ADDR_W. It stays set until rst.
- Reset values: rptr=0, core_data_out=0, core_valid_out=0, io_token_out=0, overrun=0, buffer_ren=0, low-half register=0, token counter=0, state=FETCH_LO.
- Reset mid-operation discards any partially assembled word and any pending token pulse. The input stage must be reset in the same cycle so that wptr=0.

## Timing
- buffer_ren and buffer_raddr are combinational from state, rptr and wptr. All other outputs are registered.
- Latency: two entries present while in FETCH_LO at cycle T → core_valid_out=1 at T+4.
- Single entry available: the FSM parks in FETCH_HI. The second entry becoming visible at cycle U → core_valid_out=1 at U+2.
- Back-to-back throughput: one word per 5 cycles when core_ready is held at 1.
- core_data_out is stable while core_valid_out=1 and core_ready=0.
- Simultaneous events:
  - A wptr change in the same cycle as a FETCH decision is not seen until the next cycle.
  - Handshake and reset in the same cycle: reset wins, no word is recorded.

## Structure
- Shared package bsg_downstream_pkg holds:
  - ADDR_W and PTR_W = ADDR_W+1, shared with the input stage;
  - the state enum (FETCH_LO, CAP_LO, FETCH_HI, CAP_HI, PRESENT);
  - the TOKEN_BATCH default.
- One sub-module, bsg_token_batcher: read-pulse in → counter → registered io_token_out pulse. It is reusable by the upstream channel.

## Test plan
- Reset: assert rst with the FSM in PRESENT → next cycle all outputs 0 and state FETCH_LO. Holding core_ready=1 produces no handshake.
- Basic: entries 0x3412 and 0x7856 at addresses 0 and 1, wptr=2 at T → core_valid_out=1 at T+4 with core_data_out=0x78563412, rptr=2. core_ready=1 → valid drops the next cycle.
- Backpressure: wptr=6, core_ready=0 for 10 cycles after first valid → data held at 0x78563412, rptr stays 2, no buffer_ren.
- Partial word: wptr=1 → low half captured, no valid. wptr=2 at U → valid at U+2.
- Wrap and credits: stream 130 entries with core_ready=1 → rptr passes 127→0, all 65 words in order. 32 io_token_out pulses appear by the time the 128th read is issued, each one cycle wide.
- Overrun: with rptr=0, drive wptr=65 → overrun=1 the next cycle and it stays 1 until rst.
